// File: rtl/mem_write.sv
`default_nettype none
// ============================================================================
// Module   : mem_write
// Purpose  : Streams one N-coefficient polynomial from a dual-port BRAM as
//            N/2 packed 64-bit AXI-stream beats, credit-checked against a
//            small output buffer so any downstream backpressure is tolerated.
// Options  : `define CENTERED_OUT_EN -> signed centred output, one extra stage.
// Revision : 1.0 - initial release
// ============================================================================
module mem_write #(
    parameter int Q      = 8380417,
    parameter int N      = 256,
    parameter int RD_LAT = 1,
    parameter int BUF_D  = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   module_start,
    input  logic                   write_working,
    output logic                   coef_ena,
    output logic [$clog2(N)-1:0]   coef_addra,
    input  logic [$clog2(Q)-1:0]   coef_douta,
    output logic                   coef_enb,
    output logic [$clog2(N)-1:0]   coef_addrb,
    input  logic [$clog2(Q)-1:0]   coef_doutb,
    output logic                   Wm_tvalid,
    input  logic                   Wm_tready,
    output logic [63:0]            Wm_tdata,
    output logic                   Wm_tlast,
    output logic                   module_done
);

    localparam int CWID  = $clog2(Q);
    localparam int AW    = $clog2(N);
    localparam int BEATS = N / 2;
    localparam int BW    = $clog2(BEATS);
    localparam int PW    = $clog2(BUF_D);
    localparam int OW    = PW + 1;
`ifdef CENTERED_OUT_EN
    localparam int PIPE  = RD_LAT + 1;
`else
    localparam int PIPE  = RD_LAT;
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [AW-1:0]     rd_idx;
    logic [BW-1:0]     beat_cnt;
    logic [PIPE-1:0]   vld_sr;
    logic [OW-1:0]     inflight;
    logic [OW-1:0]     occ;
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [63:0]       buf_mem [BUF_D];
    logic [63:0]       push_data;

    logic              has_credit;
    logic              issue;
    logic              last_issue;
    logic              push;
    logic              pop;
    logic              last_pop;

    // Reads already in flight hold a reserved slot, so a capture always finds room.
    assign has_credit = ({1'b0, occ} + {1'b0, inflight}) < (OW + 1)'(BUF_D);
    assign issue      = (state == S_RUN) && write_working && !module_start && has_credit;
    assign last_issue = issue && (rd_idx == AW'(N - 2));
    assign push       = vld_sr[PIPE-1];
    assign pop        = Wm_tvalid && Wm_tready;
    assign last_pop   = pop && (beat_cnt == BW'(BEATS - 1));

    assign coef_ena   = issue;
    assign coef_enb   = issue;
    assign coef_addra = issue ? rd_idx : '0;
    assign coef_addrb = issue ? (rd_idx + AW'(1)) : '0;

    assign Wm_tvalid   = (occ != '0);
    assign Wm_tdata    = Wm_tvalid ? buf_mem[rd_ptr] : '0;
    assign Wm_tlast    = Wm_tvalid && (beat_cnt == BW'(BEATS - 1));
    assign module_done = (state == S_DONE);

`ifdef CENTERED_OUT_EN
    function automatic logic [31:0] center(input logic [CWID-1:0] c);
        logic [31:0] c32;
        c32 = 32'(c);
        if (c32 > 32'((Q - 1) / 2))
            center = c32 - 32'(Q);
        else
            center = c32;
    endfunction

    logic [63:0] cen_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cen_data <= '0;
        else if (vld_sr[RD_LAT-1])
            cen_data <= {center(coef_doutb), center(coef_douta)};
    end

    assign push_data = cen_data;
`else
    assign push_data = {32'(coef_doutb), 32'(coef_douta)};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (module_start) begin
            state_nxt = S_RUN;
        end else begin
            case (state)
                S_IDLE:  state_nxt = S_IDLE;
                S_RUN:   if (last_issue) state_nxt = S_DRAIN;
                S_DRAIN: if (last_pop)   state_nxt = S_DONE;
                S_DONE:  state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    generate
        if (PIPE == 1) begin : g_sr_single
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    vld_sr <= '0;
                else if (module_start)
                    vld_sr <= '0;
                else
                    vld_sr <= issue;
            end
        end else begin : g_sr_multi
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    vld_sr <= '0;
                else if (module_start)
                    vld_sr <= '0;
                else
                    vld_sr <= {vld_sr[PIPE-2:0], issue};
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_idx   <= '0;
            beat_cnt <= '0;
            inflight <= '0;
            occ      <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else if (module_start) begin
            rd_idx   <= '0;
            beat_cnt <= '0;
            inflight <= '0;
            occ      <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else begin
            if (issue)
                rd_idx <= last_issue ? '0 : rd_idx + AW'(2);

            case ({issue, push})
                2'b10:   inflight <= inflight + OW'(1);
                2'b01:   inflight <= inflight - OW'(1);
                default: inflight <= inflight;
            endcase

            case ({push, pop})
                2'b10:   occ <= occ + OW'(1);
                2'b01:   occ <= occ - OW'(1);
                default: occ <= occ;
            endcase

            if (push)
                wr_ptr <= wr_ptr + PW'(1);

            if (pop) begin
                rd_ptr   <= rd_ptr + PW'(1);
                beat_cnt <= last_pop ? '0 : beat_cnt + BW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !module_start)
            buf_mem[wr_ptr] <= push_data;
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        (push && !pop) |-> (occ < OW'(BUF_D)));

    a_axi_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (Wm_tvalid && !Wm_tready && !module_start) |=> (Wm_tvalid && $stable(Wm_tdata)));

endmodule
`default_nettype wire

// File: tb/tb_mem_write.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_write
// Purpose  : Scoreboard bench for mem_write: stimulus queues expected beats,
//            a negedge monitor pops and compares every accepted beat.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_write;

    localparam int Q     = 8380417;
    localparam int BUF_D = 4;
`ifdef CENTERED_OUT_EN
    localparam int EXP_LAT = 3;
`else
    localparam int EXP_LAT = 2;
`endif

    typedef struct packed {
        logic [63:0] d;
        logic        l;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        module_start = 1'b0;
    logic        write_working = 1'b0;
    logic        coef_ena, coef_enb;
    logic [7:0]  coef_addra, coef_addrb;
    logic [22:0] coef_douta = '0;
    logic [22:0] coef_doutb = '0;
    logic        Wm_tvalid, Wm_tlast, module_done;
    logic        Wm_tready = 1'b0;
    logic [63:0] Wm_tdata;

    logic [22:0] mem [256];
    beat_t       exp_q [$];

    int cyc = 0, chk = 0, err = 0;
    int hs_count = 0, done_cnt = 0, done_due = -1, last_hs = -1;
    int first_ena = -1, first_vld = -1, reads = 0;
    int rmode = 0;
    bit          prev_stall = 1'b0;
    logic [63:0] prev_data = '0;
    logic        prev_last = 1'b0;

    mem_write dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .module_start  (module_start),
        .write_working (write_working),
        .coef_ena      (coef_ena),
        .coef_addra    (coef_addra),
        .coef_douta    (coef_douta),
        .coef_enb      (coef_enb),
        .coef_addrb    (coef_addrb),
        .coef_doutb    (coef_doutb),
        .Wm_tvalid     (Wm_tvalid),
        .Wm_tready     (Wm_tready),
        .Wm_tdata      (Wm_tdata),
        .Wm_tlast      (Wm_tlast),
        .module_done   (module_done)
    );

    initial forever #5 clk = ~clk;

    // One-cycle-latency dual-port BRAM model
    always @(posedge clk) begin
        if (coef_ena) coef_douta <= mem[coef_addra];
        if (coef_enb) coef_doutb <= mem[coef_addrb];
    end

    // 0: ready+enable high, 1: random ready/enable, 2: ready held low
    initial forever begin
        @(posedge clk); #1;
        case (rmode)
            1:       begin Wm_tready = 1'($urandom_range(0, 1)); write_working = ($urandom_range(0, 3) != 0); end
            2:       begin Wm_tready = 1'b0; write_working = 1'b1; end
            default: begin Wm_tready = 1'b1; write_working = 1'b1; end
        endcase
    end

    always @(negedge clk) begin
        beat_t e;
        cyc++;
        if (!rst_n) begin
            prev_stall = 1'b0;
            done_due   = -1;
        end else begin
            if (prev_stall) begin
                chk++;
                if (!(Wm_tvalid && Wm_tdata === prev_data && Wm_tlast === prev_last)) begin
                    err++;
                    $display("FAIL stall_hold: cyc=%0d got v=%b d=%h l=%b, required v=1 d=%h l=%b",
                             cyc, Wm_tvalid, Wm_tdata, Wm_tlast, prev_data, prev_last);
                end
            end
            if (module_start) begin
                reads = 0; first_ena = -1; first_vld = -1;
            end else begin
                if (coef_ena) reads++;
                if (coef_ena && first_ena < 0) first_ena = cyc;
                if (Wm_tvalid && first_vld < 0) first_vld = cyc;
            end
            if (Wm_tvalid && Wm_tready && !module_start) begin
                hs_count++;
                chk++;
                if (exp_q.size() == 0) begin
                    err++;
                    $display("FAIL extra_beat: got d=%h l=%b, required no beat", Wm_tdata, Wm_tlast);
                end else begin
                    e = exp_q.pop_front();
                    if (Wm_tdata !== e.d || Wm_tlast !== e.l) begin
                        err++;
                        $display("FAIL beat: got d=%h l=%b, required d=%h l=%b", Wm_tdata, Wm_tlast, e.d, e.l);
                    end
                    if (e.l) begin
                        done_due = cyc + 1;
                        last_hs  = cyc;
                    end
                end
            end
            if (module_done || done_due == cyc) begin
                chk++;
                if (!(module_done && done_due == cyc)) begin
                    err++;
                    $display("FAIL done_timing: cyc=%0d got done=%b, required pulse at cyc %0d", cyc, module_done, done_due);
                end
                if (module_done) done_cnt++;
                if (done_due == cyc) done_due = -1;
            end
            prev_stall = Wm_tvalid && !Wm_tready && !module_start;
            prev_data  = Wm_tdata;
            prev_last  = Wm_tlast;
        end
    end

    task automatic check(input string nm, input longint got, input longint req);
        chk++;
        if (got != req) begin
            err++;
            $display("FAIL %s: got %0d, required %0d", nm, got, req);
        end
    endtask

    task automatic check_zero(input string nm);
        logic [154:0] o;
        o = {coef_ena, coef_enb, coef_addra, coef_addrb, Wm_tvalid, Wm_tdata, Wm_tlast, module_done};
        chk++;
        if (o !== '0) begin
            err++;
            $display("FAIL %s: outputs=%h, required all zero", nm, o);
        end
    endtask

    task automatic load_ramp();
        for (int i = 0; i < 256; i++) mem[i] = 23'(i);
    endtask

    task automatic push_exp(input bit cen);
        beat_t b;
        for (int k = 0; k < 128; k++) begin
            b.d = {32'(mem[2*k+1]), 32'(mem[2*k])};
            b.l = (k == 127);
            if (cen && k == 0) begin
`ifdef CENTERED_OUT_EN
                b.d = {32'h003FF000, 32'hFFFFFFFF};
`else
                b.d = {32'h003FF000, 32'h007FE000};
`endif
            end
            if (cen && k == 1) begin
`ifdef CENTERED_OUT_EN
                b.d[31:0] = 32'hFFC01000;
`else
                b.d[31:0] = 32'h003FF001;
`endif
            end
            exp_q.push_back(b);
        end
    endtask

    task automatic start_poly(input bit cen);
        @(posedge clk); #1;
        module_start = 1'b1;
        exp_q.delete();
        push_exp(cen);
        @(posedge clk); #1;
        module_start = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int target, input int budget);
        int n = 0;
        while (done_cnt < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        chk++;
        if (done_cnt < target) begin
            err++;
            $display("FAIL %s_timeout: got done_cnt=%0d, required %0d", nm, done_cnt, target);
        end
        check({nm, "_queue_empty"}, exp_q.size(), 0);
    endtask

    task automatic wait_beats(input string nm, input int n_beats);
        int base = hs_count;
        int n = 0;
        while (hs_count - base < n_beats && n < 2000) begin
            @(posedge clk);
            n++;
        end
        check({nm, "_beats_reached"}, (hs_count - base >= n_beats) ? 1 : 0, 1);
    endtask

    initial begin
        int d0;
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        load_ramp();
        repeat (3) @(posedge clk);
        #1 check_zero("reset_outputs");
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1 check_zero("idle_outputs");

        // Full-rate ramp
        rmode = 0;
        start_poly(1'b0);
        wait_done("ramp", 1, 1000);
        check("first_latency", first_vld - first_ena, EXP_LAT);
        check("throughput", last_hs - first_vld, 127);

        // Random ready and enable
        rmode = 1;
        start_poly(1'b0);
        wait_done("random", 2, 4000);
        rmode = 0;

        // Ready held low: reads bounded by buffer depth, beat 0 held
        rmode = 2;
        start_poly(1'b0);
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("stall_reads_bounded", (reads <= BUF_D) ? 1 : 0, 1);
        check("stall_tvalid", Wm_tvalid, 1);
        check("stall_beat0", Wm_tdata, 64'h00000001_00000000);
        rmode = 0;
        wait_done("stall", 3, 1000);

        // Conversion boundary values
        mem[0] = 23'(Q - 1);
        mem[1] = 23'd4190208;
        mem[2] = 23'd4190209;
        start_poly(1'b1);
        wait_done("convert", 4, 1000);
        load_ramp();

        // Restart after 40 beats: no done for the aborted polynomial
        start_poly(1'b0);
        wait_beats("restart", 40);
        d0 = done_cnt;
        start_poly(1'b0);
        wait_done("restart", d0 + 1, 1000);
        repeat (5) @(posedge clk);
        check("restart_single_done", done_cnt, d0 + 1);

        // Asynchronous reset mid-run, then clean restart
        start_poly(1'b0);
        wait_beats("areset", 30);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1 check_zero("async_reset_outputs");
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        d0 = done_cnt;
        start_poly(1'b0);
        wait_done("after_reset", d0 + 1, 1000);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", err, chk);
        $finish;
    end

endmodule
`default_nettype wire
